// File: rtl/reflex_ctrl.sv
// Reaction-time trial sequencer: base delay, error-penalty wait, then times the
// player's response. Drives the wait_count penalty counter that sits downstream.
module reflex_ctrl #(
  parameter int DELAY_TICKS   = 1000,
  parameter int PENALTY_TICKS = 500,
  parameter int MAX_TICKS     = 999,
  parameter int RW            = 10
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          start,
  input  logic          press,
  input  logic          tick,
  input  logic          end_wait,
  output logic          load_wait,
  output logic          dec_wait,
  output logic [1:0]    new_error_count,
  output logic          led,
  output logic [RW-1:0] reaction,
  output logic          valid,
  output logic          too_slow
);

  localparam int MAXV = (DELAY_TICKS > PENALTY_TICKS)
                      ? ((DELAY_TICKS > MAX_TICKS) ? DELAY_TICKS : MAX_TICKS)
                      : ((PENALTY_TICKS > MAX_TICKS) ? PENALTY_TICKS : MAX_TICKS);
  localparam int TW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

  localparam logic [TW-1:0] D_LAST = TW'(DELAY_TICKS - 1);
  localparam logic [TW-1:0] P_LAST = TW'(PENALTY_TICKS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(MAX_TICKS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DELAY   = 3'd2,
    PENALTY = 3'd3,
    GO      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state;
  logic [1:0]    err_cnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    err_inc;

  assign err_inc         = (err_cnt == 2'd3) ? 2'd3 : err_cnt + 2'd1;
  assign new_error_count = err_cnt;
  assign load_wait       = (state == LOAD);
  assign led             = (state == GO);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_cnt  <= 2'd0;
      tcnt     <= '0;
      reaction <= '0;
      too_slow <= 1'b0;
      dec_wait <= 1'b0;
      valid    <= 1'b0;
    end else begin
      dec_wait <= 1'b0;
      valid    <= 1'b0;
      unique case (state)
        IDLE: begin
          err_cnt <= 2'd0;
          if (start) state <= LOAD;
        end
        LOAD: begin
          tcnt  <= '0;
          state <= DELAY;
        end
        DELAY: begin
          // a press always beats a coincident tick
          if (press) begin
            err_cnt <= err_inc;
            state   <= LOAD;
          end else if (tick) begin
            if (tcnt == D_LAST) begin
              tcnt  <= '0;
              state <= PENALTY;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        PENALTY: begin
          if (press) begin
            err_cnt <= err_inc;
            state   <= LOAD;
          end else if (end_wait) begin
            tcnt  <= '0;
            state <= GO;
          end else if (tick) begin
            if (tcnt == P_LAST) begin
              tcnt     <= '0;
              dec_wait <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        GO: begin
          if (press) begin
            reaction <= RW'(tcnt);
            too_slow <= 1'b0;
            valid    <= 1'b1;
            err_cnt  <= 2'd0;
            state    <= DONE;
          end else if (tick) begin
            if (tcnt == T_LAST) begin
              reaction <= RW'(MAX_TICKS);
              too_slow <= 1'b1;
              valid    <= 1'b1;
              state    <= DONE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        DONE: begin
          if (start) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_excl:  assert property (@(posedge ck) disable iff (!rst_n) !(load_wait && dec_wait));
  a_valid: assert property (@(posedge ck) disable iff (!rst_n) valid |=> !valid);

endmodule

// File: tb/tb_reflex_ctrl.sv
// Scoreboard bench for reflex_ctrl: a trial-level planner lays out the stimulus
// schedule and the expected event timeline; a monitor matches DUT events to it.
module tb_reflex_ctrl;
  localparam int DT = 4, PT = 2, MT = 7, RW = 10, NCYC = 8192;
  localparam int EV_LOAD = 0, EV_DEC = 1, EV_LED = 2, EV_VALID = 3;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  logic          ck = 1'b0, rst_n = 1'b1, start = 1'b0, press = 1'b0, tick = 1'b0;
  logic          end_wait, load_wait, dec_wait, led, valid, too_slow;
  logic [1:0]    new_error_count;
  logic [RW-1:0] reaction;
  logic [1:0]    wcnt;

  int  cur = -1, n_cmp = 0, n_bad = 0, now = 1, err = 0, last = 0;
  bit  start_at[NCYC], press_at[NCYC], rst_at[NCYC];
  bit  led_q = 1'b0;
  ev_t expq[$];

  reflex_ctrl #(.DELAY_TICKS(DT), .PENALTY_TICKS(PT), .MAX_TICKS(MT), .RW(RW)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .press(press), .tick(tick),
    .end_wait(end_wait), .load_wait(load_wait), .dec_wait(dec_wait),
    .new_error_count(new_error_count), .led(led), .reaction(reaction),
    .valid(valid), .too_slow(too_slow)
  );

  always #5 ck = ~ck;

  // behavioural wait_count neighbour
  always @(posedge ck or negedge rst_n) begin
    if (!rst_n)                    wcnt <= 2'd0;
    else if (load_wait)            wcnt <= new_error_count;
    else if (dec_wait && wcnt != 0) wcnt <= wcnt - 2'd1;
  end
  assign end_wait = (wcnt == 2'd0);

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cur, act, exp);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_load_wait"}, int'(load_wait), 0);
    chk({tag, "_dec_wait"}, int'(dec_wait), 0);
    chk({tag, "_led"}, int'(led), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_too_slow"}, int'(too_slow), 0);
    chk({tag, "_reaction"}, int'(reaction), 0);
    chk({tag, "_err_count"}, int'(new_error_count), 0);
  endtask

  function automatic void push(int kind, int cyc, int data);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.data = data;
    expq.push_back(e);
  endfunction

  // ticks occur on even cycles
  function automatic int nth_tick(int from, int n);
    return ((from % 2 == 0) ? from : from + 1) + 2 * (n - 1);
  endfunction

  // penalty decrements for the current error count, those landing at or before lim
  function automatic void push_decs(int td, int lim);
    for (int j = 1; j <= err; j++) begin
      int d;
      d = nth_tick(td + 1, PT * j) + 1;
      if (d <= lim) push(EV_DEC, d, err);
    end
  endfunction

  task automatic plan_trial(int npre, bit pre_coin, bit timeout, int r, bit go_coin,
                            bit sgo, bit rst_pen);
    int s, L, td, G, p, q, e_end, rc, lo, hi;
    s = now + 1 + $urandom_range(0, 3);
    if ($urandom_range(0, 1) == 1) press_at[$urandom_range(now, s)] = 1'b1;
    start_at[s] = 1'b1;
    L  = s + 1;
    td = 0;
    G  = 0;
    for (int a = 0; a <= npre; a++) begin
      push(EV_LOAD, L, err);
      td = nth_tick(L + 1, DT);
      G  = (err == 0) ? td + 2 : nth_tick(td + 1, PT * err) + 3;
      if (a < npre) begin
        p = pre_coin ? nth_tick(L + 1, $urandom_range(1, DT)) : $urandom_range(L + 1, G - 1);
        push_decs(td, p);
        press_at[p] = 1'b1;
        err = (err == 3) ? 3 : err + 1;
        L = p + 1;
      end
    end
    if (rst_pen) begin
      rc = $urandom_range(td + 1, G - 1);
      push_decs(td, rc - 1);
      rst_at[rc] = 1'b1;
      err = 0;
      now = rc + 1;
      return;
    end
    push_decs(td, G);
    push(EV_LED, G, 0);
    if (timeout) begin
      e_end = nth_tick(G, MT + 1);
      push(EV_VALID, e_end + 1, (1 << 16) | MT);
    end else begin
      lo = (r == 0) ? G : nth_tick(G, r) + 1;
      hi = nth_tick(G, r + 1);
      q  = go_coin ? hi : $urandom_range(lo, hi);
      press_at[q] = 1'b1;
      e_end = q;
      push(EV_VALID, q + 1, r);
      err = 0;
    end
    if (sgo) start_at[$urandom_range(G, e_end)] = 1'b1;
    now = e_end + 1;
  endtask

  always @(negedge ck) begin : mon
    int  k, d;
    bit  got;
    ev_t e;
    if (rst_n && cur >= 0) begin
      if (load_wait || dec_wait) chk("load_dec_exclusive", int'(load_wait & dec_wait), 0);
      got = 1'b1;
      k = 0;
      d = 0;
      if (load_wait)          begin k = EV_LOAD;  d = int'(new_error_count); end
      else if (dec_wait)      begin k = EV_DEC;   d = int'(new_error_count); end
      else if (led && !led_q) begin k = EV_LED;   d = 0; end
      else if (valid)         begin
        k = EV_VALID;
        d = (int'(too_slow) << 16) | (int'(led) << 15) | int'(reaction);
      end
      else got = 1'b0;
      if (got) begin
        if (expq.size() == 0) begin
          chk("unexpected_event_kind", k, -1);
        end else begin
          e = expq.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cycle", cur, e.cyc);
          chk("event_data", d, e.data);
        end
      end
    end
    led_q <= led;
  end

  initial begin
    plan_trial(0, 0, 0, 5, 0, 1, 0);                       // clean, reaction 5, start in GO
    plan_trial(1, 0, 0, $urandom_range(0, MT), 0, 0, 0);   // one early press
    plan_trial(4, 0, 0, 2, 0, 0, 0);                       // error count saturates
    plan_trial(0, 0, 1, 0, 0, 1, 0);                       // timeout, start in GO
    plan_trial(1, 1, 0, 3, 1, 0, 0);                       // press on tick in DELAY and GO
    plan_trial(2, 0, 0, 0, 0, 0, 1);                       // reset mid-penalty
    repeat (24) begin
      if (now < NCYC - 400)
        plan_trial($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, MT),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0));
    end
    last = now + 20;

    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge ck); #1 chk_zero("reset_hold");

    for (int c = 0; c < last; c++) begin
      @(posedge ck); #1;
      cur   = c;
      rst_n = 1'b1;
      start = start_at[c];
      press = press_at[c];
      tick  = (c % 2 == 0);
      if (rst_at[c]) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
      end
    end
    @(posedge ck); #1;
    start = 1'b0;
    press = 1'b0;
    chk("events_left_unmatched", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
